// File: rtl/nn_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the neuron blocks.
// Holds FSM encoding and the 16-bit saturation helper.
package nn_fixed_pkg;

    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 8;
    localparam int unsigned PW   = 24;
    localparam int unsigned SW   = 26;
    localparam int unsigned EW   = W + 2;

    localparam logic [W-1:0] Q88_ONE = 16'h0100;
    localparam logic [W-1:0] Q88_MAX = 16'h7FFF;
    localparam logic [W-1:0] Q88_MIN = 16'h8000;

    localparam logic signed [EW-1:0] EXT_MAX = 18'sd32767;
    localparam logic signed [EW-1:0] EXT_MIN = -18'sd32768;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL_A  = 3'd1,
        ST_MUL_B  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Clamp an 18-bit signed intermediate into the Q8.8 range.
    function automatic logic [W-1:0] sat16(input logic signed [EW-1:0] x);
        if (x > EXT_MAX) begin
            return Q88_MAX;
        end else if (x < EXT_MIN) begin
            return Q88_MIN;
        end else begin
            return W'(x);
        end
    endfunction

endpackage

// File: rtl/q88_mul.sv
// Combinational signed Q8.8 x Q8.8 multiply, floor-truncated back by FRAC bits.
module q88_mul
    import nn_fixed_pkg::*;
(
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    output logic signed [PW-1:0] p_c
);

    logic signed [2*W-1:0] prod;

    assign prod = x * y;
    assign p_c  = PW'(prod >>> FRAC);

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron-rule trainer for the 2-input Q8.8 step neuron.
// One shared multiplier evaluates A*cA then B*cB before the weight update.
module perceptron_trainer
    import nn_fixed_pkg::*;
#(
    parameter int unsigned LR_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic [15:0]  init_ca,
    input  logic [15:0]  init_cb,
    input  logic [15:0]  init_bias,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [15:0]  s_a,
    input  logic [15:0]  s_b,
    input  logic         s_target,
    output logic         r_valid,
    input  logic         r_ready,
    output logic         r_f,
    output logic [1:0]   r_err,
    output logic [15:0]  o_ca,
    output logic [15:0]  o_cb,
    output logic [15:0]  o_bias,
    output logic [15:0]  upd_count
);

    localparam logic signed [W-1:0] BIAS_STEP = W'(Q88_ONE >> LR_SHIFT);

    state_t state_q, state_d;

    logic signed [W-1:0]  a_q, b_q;
    logic                 t_q;
    logic signed [PW-1:0] pa_q, pb_q;

    logic signed [W-1:0]  mul_x, mul_y;
    logic signed [PW-1:0] mul_p_c;
    logic signed [SW-1:0] sum_c;
    logic                 f_c;
    logic [1:0]           err_c;
    logic signed [W-1:0]  da_c, db_c;
    logic [W-1:0]         ca_nxt_c, cb_nxt_c, bias_nxt_c;

    assign s_ready = (state_q == ST_IDLE) && !init;

    // Shared multiplier: B/cB only during MUL_B, A/cA otherwise.
    assign mul_x = (state_q == ST_MUL_B) ? b_q : a_q;
    assign mul_y = (state_q == ST_MUL_B) ? $signed(o_cb) : $signed(o_ca);

    q88_mul u_mul (
        .x   (mul_x),
        .y   (mul_y),
        .p_c (mul_p_c)
    );

    // Forward evaluation and perceptron-rule candidate weights.
    always_comb begin
        sum_c = $signed({{2{pa_q[PW-1]}}, pa_q})
              + $signed({{2{pb_q[PW-1]}}, pb_q})
              + $signed({{(SW-W){o_bias[W-1]}}, o_bias});
        f_c   = !sum_c[SW-1] && (sum_c != '0);
        err_c = 2'b00;
        if (t_q && !f_c) begin
            err_c = 2'b01;
        end else if (!t_q && f_c) begin
            err_c = 2'b11;
        end
        da_c = a_q >>> LR_SHIFT;
        db_c = b_q >>> LR_SHIFT;
        if (err_c[1]) begin
            ca_nxt_c   = sat16($signed({{2{o_ca[W-1]}}, o_ca}) - $signed({{2{da_c[W-1]}}, da_c}));
            cb_nxt_c   = sat16($signed({{2{o_cb[W-1]}}, o_cb}) - $signed({{2{db_c[W-1]}}, db_c}));
            bias_nxt_c = sat16($signed({{2{o_bias[W-1]}}, o_bias}) - $signed({{2{BIAS_STEP[W-1]}}, BIAS_STEP}));
        end else begin
            ca_nxt_c   = sat16($signed({{2{o_ca[W-1]}}, o_ca}) + $signed({{2{da_c[W-1]}}, da_c}));
            cb_nxt_c   = sat16($signed({{2{o_cb[W-1]}}, o_cb}) + $signed({{2{db_c[W-1]}}, db_c}));
            bias_nxt_c = sat16($signed({{2{o_bias[W-1]}}, o_bias}) + $signed({{2{BIAS_STEP[W-1]}}, BIAS_STEP}));
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (s_valid) state_d = ST_MUL_A;
                ST_MUL_A:  state_d = ST_MUL_B;
                ST_MUL_B:  state_d = ST_UPDATE;
                ST_UPDATE: state_d = ST_RESP;
                ST_RESP:   if (r_ready) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: init overrides everything; weights move only in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= 1'b0;
            pa_q      <= '0;
            pb_q      <= '0;
            r_valid   <= 1'b0;
            r_f       <= 1'b0;
            r_err     <= 2'b00;
            o_ca      <= '0;
            o_cb      <= '0;
            o_bias    <= '0;
            upd_count <= '0;
        end else if (init) begin
            o_ca      <= init_ca;
            o_cb      <= init_cb;
            o_bias    <= init_bias;
            upd_count <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        a_q <= s_a;
                        b_q <= s_b;
                        t_q <= s_target;
                    end
                end
                ST_MUL_A: pa_q <= mul_p_c;
                ST_MUL_B: pb_q <= mul_p_c;
                ST_UPDATE: begin
                    r_valid <= 1'b1;
                    r_f     <= f_c;
                    r_err   <= err_c;
                    if (err_c != 2'b00) begin
                        o_ca      <= ca_nxt_c;
                        o_cb      <= cb_nxt_c;
                        o_bias    <= bias_nxt_c;
                        upd_count <= upd_count + 16'd1;
                    end
                end
                ST_RESP: if (r_ready) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: stimulus pushes expected results,
// a negedge monitor pops and compares on each accepted response.
module tb_perceptron_trainer;

    typedef struct {
        logic        f;
        logic [1:0]  err;
        logic [15:0] ca;
        logic [15:0] cb;
        logic [15:0] bias;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic [15:0] init_ca, init_cb, init_bias;
    logic        s_valid, s_ready;
    logic [15:0] s_a, s_b;
    logic        s_target;
    logic        r_valid, r_ready, r_f;
    logic [1:0]  r_err;
    logic [15:0] o_ca, o_cb, o_bias, upd_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    perceptron_trainer #(.LR_SHIFT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .init_ca   (init_ca),
        .init_cb   (init_cb),
        .init_bias (init_bias),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_target  (s_target),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_f       (r_f),
        .r_err     (r_err),
        .o_ca      (o_ca),
        .o_cb      (o_cb),
        .o_bias    (o_bias),
        .upd_count (upd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [1:0] err, input logic [15:0] ca,
                                input logic [15:0] cb, input logic [15:0] bias, input logic [15:0] cnt);
        exp_t e;
        e.f = f; e.err = err; e.ca = ca; e.cb = cb; e.bias = bias; e.cnt = cnt;
        return e;
    endfunction

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got r_valid=1 expected no response at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("r_f",       32'(r_f),       32'(mon_e.f));
                chk("r_err",     32'(r_err),     32'(mon_e.err));
                chk("o_ca",      32'(o_ca),      32'(mon_e.ca));
                chk("o_cb",      32'(o_cb),      32'(mon_e.cb));
                chk("o_bias",    32'(o_bias),    32'(mon_e.bias));
                chk("upd_count", 32'(upd_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic do_init(input logic [15:0] ca, input logic [15:0] cb, input logic [15:0] bias);
        @(negedge clk);
        init = 1'b1; init_ca = ca; init_cb = cb; init_bias = bias;
        #1 chk("s_ready_during_init", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1 init = 1'b0;
        @(negedge clk);
        chk("init_ca",   32'(o_ca),      32'(ca));
        chk("init_cb",   32'(o_cb),      32'(cb));
        chk("init_bias", 32'(o_bias),    32'(bias));
        chk("init_cnt",  32'(upd_count), 32'd0);
    endtask

    // Issue one sample and check r_valid appears 3 edges after the handshake edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic t, input exp_t e);
        int n;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n >= 50), 32'd0);
        s_a = a; s_b = b; s_target = t; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_valid && n < 20);
        chk("latency", 32'(n), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; init = 1'b0; init_ca = '0; init_cb = '0; init_bias = '0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_target = 1'b0; r_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_ca",      32'(o_ca),      32'd0);
        chk("rst_cb",      32'(o_cb),      32'd0);
        chk("rst_bias",    32'(o_bias),    32'd0);
        chk("rst_r_valid", 32'(r_valid),   32'd0);
        chk("rst_s_ready", 32'(s_ready),   32'd1);
        chk("rst_cnt",     32'(upd_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct prediction leaves weights alone
        do_init(16'h0100, 16'h0100, 16'h0000);
        send(16'h0100, 16'h0100, 1'b1, mk(1'b1, 2'b00, 16'h0100, 16'h0100, 16'h0000, 16'd0));

        // sum == 0 predicts 0, positive update
        do_init(16'h0100, 16'hFF00, 16'h0000);
        send(16'h0100, 16'h0100, 1'b1, mk(1'b0, 2'b01, 16'h0140, 16'hFF40, 16'h0040, 16'd1));

        // Saturation at the positive rail
        do_init(16'h7FF0, 16'h8000, 16'h0000);
        send(16'h0100, 16'h0100, 1'b1, mk(1'b0, 2'b01, 16'h7FFF, 16'h8040, 16'h0040, 16'd1));

        // Backpressure: result and weights held, no new sample accepted
        do_init(16'h0100, 16'h0000, 16'h0000);
        r_ready = 1'b0;
        send(16'h0100, 16'h0000, 1'b0, mk(1'b1, 2'b11, 16'h00C0, 16'h0000, 16'hFFC0, 16'd1));
        s_a = 16'h7777; s_b = 16'h7777; s_target = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_r_valid", 32'(r_valid), 32'd1);
            chk("bp_r_err",   32'(r_err),   32'd3);
            chk("bp_ca",      32'(o_ca),    32'h00C0);
            chk("bp_bias",    32'(o_bias),  32'hFFC0);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1 s_valid = 1'b0; r_ready = 1'b1;

        // Bias walks negative with target 0
        do_init(16'h0400, 16'h0000, 16'h0000);
        send(16'h0100, 16'h0000, 1'b0, mk(1'b1, 2'b11, 16'h03C0, 16'h0000, 16'hFFC0, 16'd1));
        send(16'h0100, 16'h0000, 1'b0, mk(1'b1, 2'b11, 16'h0380, 16'h0000, 16'hFF80, 16'd2));
        send(16'h0100, 16'h0000, 1'b0, mk(1'b1, 2'b11, 16'h0340, 16'h0000, 16'hFF40, 16'd3));
        send(16'h0100, 16'h0000, 1'b0, mk(1'b1, 2'b11, 16'h0300, 16'h0000, 16'hFF00, 16'd4));

        // init during MUL_B drops the sample
        @(negedge clk);
        s_a = 16'h0100; s_b = 16'h0100; s_target = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(posedge clk);
        #1 init = 1'b1; init_ca = 16'h0200; init_cb = 16'h0300; init_bias = 16'h0010;
        @(posedge clk);
        #1 init = 1'b0;
        @(negedge clk);
        chk("abort_s_ready", 32'(s_ready), 32'd1);
        chk("abort_r_valid", 32'(r_valid), 32'd0);
        chk("abort_ca",      32'(o_ca),    32'h0200);
        chk("abort_cb",      32'(o_cb),    32'h0300);
        chk("abort_bias",    32'(o_bias),  32'h0010);
        repeat (6) @(negedge clk);
        chk("abort_no_resp", 32'(r_valid), 32'd0);

        // Reset mid-operation returns to reset values
        @(negedge clk);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ca",      32'(o_ca),      32'd0);
        chk("mid_rst_r_valid", 32'(r_valid),   32'd0);
        chk("mid_rst_s_ready", 32'(s_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
